// File: rtl/nlprg16_if.sv
// nlprg16_if: receive-side bus for the 16-bit nonlinear PRG sequence checker.
//   in_valid   - in_data carries one generator word this cycle
//   in_data    - received generator word
//   clr_count  - synchronous clear of err_count
//   locked     - checker is in LOCKED
//   err_pulse  - one-cycle pulse per mismatched word while LOCKED
//   lost_pulse - one-cycle pulse on loss of lock
//   err_count  - saturating mismatch count (ERR_W bits)
// master: the side that drives the words (source / bench); slave: the checker.
interface nlprg16_if #(
    parameter int ERR_W = 16
) ();
    logic             in_valid;
    logic [15:0]      in_data;
    logic             clr_count;
    logic             locked;
    logic             err_pulse;
    logic             lost_pulse;
    logic [ERR_W-1:0] err_count;

    modport master (
        output in_valid, in_data, clr_count,
        input  locked, err_pulse, lost_pulse, err_count
    );

    modport slave (
        input  in_valid, in_data, clr_count,
        output locked, err_pulse, lost_pulse, err_count
    );
endinterface

// File: rtl/nlprg16_checker.sv
// nlprg16_checker: sequence checker for the 16-bit nonlinear pseudo-random
// generator stream. Self-seeds from received data (HUNT/ACQUIRE), locks after
// LOCK_CNT consecutive correct successors, then free-runs its own prediction
// (flywheel) and counts mismatches. LOSS_CNT consecutive mismatches drop lock.
// Ports:
//   CLK - clock, rising edge
//   RST - asynchronous active-high reset
//   bus - nlprg16_if slave modport (word input, clear, status outputs)
// All outputs are registered (one cycle after the sampled word).
module nlprg16_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic      CLK,
    input  logic      RST,
    nlprg16_if.slave  bus
);
    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    // Generator successor. Z injects the extra term that lets the sequence
    // pass through the all-zero state instead of sticking in it.
    function automatic logic [15:0] succ(input logic [15:0] s);
        logic [15:0] f;
        logic        z;
        z       = (s[3:0] == 4'hF) && (s[15:5] == 11'd0);
        f[0]    = ~(s[14] ^ s[15] ^ s[5]);
        f[1]    = s[12] ^ s[13] ^ s[0];
        f[2]    = s[10] ^ s[11] ^ s[1];
        f[3]    = s[8]  ^ s[9]  ^ s[2];
        f[4]    = s[6]  ^ s[7]  ^ s[3];
        f[5]    = ~(s[7] ^ s[4]) ^ z;
        f[15:6] = s[14:5];
        return f;
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      pred_q, pred_d;
    logic [3:0]       good_cnt_q, good_cnt_d;
    logic [3:0]       bad_cnt_q, bad_cnt_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic             lost_pulse_q, lost_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [3:0] good_inc, bad_inc;
    logic       match;

    always_comb begin
        state_d      = state_q;
        pred_d       = pred_q;
        good_cnt_d   = good_cnt_q;
        bad_cnt_d    = bad_cnt_q;
        err_count_d  = err_count_q;
        err_pulse_d  = 1'b0;
        lost_pulse_d = 1'b0;
        good_inc     = good_cnt_q + 4'd1;
        bad_inc      = bad_cnt_q + 4'd1;
        match        = (bus.in_data == pred_q);

        if (bus.in_valid) begin
            case (state_q)
                HUNT: begin
                    pred_d     = succ(bus.in_data);
                    good_cnt_d = 4'd0;
                    state_d    = ACQUIRE;
                end
                ACQUIRE: begin
                    // Match or not, prediction follows the received word.
                    pred_d = succ(bus.in_data);
                    if (match) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_C) begin
                            state_d   = LOCKED;
                            bad_cnt_d = 4'd0;
                        end
                    end else begin
                        good_cnt_d = 4'd0;
                    end
                end
                LOCKED: begin
                    // Flywheel: never reload from received data once locked.
                    pred_d = succ(pred_q);
                    if (match) begin
                        bad_cnt_d = 4'd0;
                    end else begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != {ERR_W{1'b1}})
                            err_count_d = err_count_q + ERR_W'(1);
                        bad_cnt_d = bad_inc;
                        if (bad_inc == LOSS_C) begin
                            state_d      = HUNT;
                            lost_pulse_d = 1'b1;
                            bad_cnt_d    = 4'd0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // Clear takes priority over a same-cycle increment.
        if (bus.clr_count)
            err_count_d = '0;

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= HUNT;
            pred_q       <= 16'd0;
            good_cnt_q   <= 4'd0;
            bad_cnt_q    <= 4'd0;
            locked_q     <= 1'b0;
            err_pulse_q  <= 1'b0;
            lost_pulse_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            pred_q       <= pred_d;
            good_cnt_q   <= good_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
            locked_q     <= locked_d;
            err_pulse_q  <= err_pulse_d;
            lost_pulse_q <= lost_pulse_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.lost_pulse = lost_pulse_q;
    assign bus.err_count  = err_count_q;
endmodule

// File: tb/tb_nlprg16_checker.sv
// Bench for nlprg16_checker. u1 uses the default parameters (LOCK 4, LOSS 3,
// 16-bit count); u2 uses LOSS 15 and a 4-bit count for saturation.
module tb_nlprg16_checker;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    nlprg16_if #(.ERR_W(16)) a1 ();
    nlprg16_if #(.ERR_W(4))  a2 ();

    nlprg16_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) u1 (
        .CLK(CLK), .RST(RST), .bus(a1)
    );
    nlprg16_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(4)) u2 (
        .CLK(CLK), .RST(RST), .bus(a2)
    );

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        clr;
        logic        lk;
        logic        ep;
        logic        lp;
        logic [15:0] cnt;
    } vec_t;

    typedef struct {
        int          id;
        int          sel;
        logic        lk;
        logic        ep;
        logic        lp;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] seq[32];
    logic [15:0] h[8];
    vec_t        tbl[23];

    // Generator successor, used only to build the stimulus stream.
    function automatic logic [15:0] gen_f(input logic [15:0] s);
        logic [15:0] f;
        f[0]    = ~(s[14] ^ s[15] ^ s[5]);
        f[1]    = s[12] ^ s[13] ^ s[0];
        f[2]    = s[10] ^ s[11] ^ s[1];
        f[3]    = s[8] ^ s[9] ^ s[2];
        f[4]    = s[6] ^ s[7] ^ s[3];
        f[5]    = ~(s[7] ^ s[4]) ^ ((s[3:0] == 4'hF) && (s[15:5] == 11'd0));
        f[15:6] = s[14:5];
        return f;
    endfunction

    function automatic vec_t mk(input logic v, input logic [15:0] d, input logic clr,
                                input logic lk, input logic ep, input logic lp,
                                input logic [15:0] cnt);
        vec_t r;
        r.v = v; r.d = d; r.clr = clr; r.lk = lk; r.ep = ep; r.lp = lp; r.cnt = cnt;
        return r;
    endfunction

    task automatic cmp(input string nm, input int id, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", nm, id, act, exp);
        end
    endtask

    task automatic check_out();
        exp_t e;
        logic lk, ep, lp;
        logic [15:0] cnt;
        e = sb.pop_front();
        if (e.sel == 1) begin
            lk = a1.locked; ep = a1.err_pulse; lp = a1.lost_pulse; cnt = a1.err_count;
        end else begin
            lk = a2.locked; ep = a2.err_pulse; lp = a2.lost_pulse; cnt = {12'd0, a2.err_count};
        end
        cmp("locked", e.id, {15'd0, lk}, {15'd0, e.lk});
        cmp("err_pulse", e.id, {15'd0, ep}, {15'd0, e.ep});
        cmp("lost_pulse", e.id, {15'd0, lp}, {15'd0, e.lp});
        cmp("err_count", e.id, cnt, e.cnt);
    endtask

    // Drive one cycle on the selected DUT (other one idles), then compare
    // the registered outputs on the following falling edge.
    task automatic step(input int sel, input logic v, input logic [15:0] d,
                        input logic clr, input logic lk, input logic ep,
                        input logic lp, input logic [15:0] cnt, input int id);
        exp_t e;
        a1.in_valid  = (sel == 1) ? v : 1'b0;
        a1.in_data   = d;
        a1.clr_count = (sel == 1) ? clr : 1'b0;
        a2.in_valid  = (sel == 2) ? v : 1'b0;
        a2.in_data   = d;
        a2.clr_count = (sel == 2) ? clr : 1'b0;
        e.id = id; e.sel = sel; e.lk = lk; e.ep = ep; e.lp = lp; e.cnt = cnt;
        sb.push_back(e);
        @(posedge CLK);
        @(negedge CLK);
        check_out();
    endtask

    task automatic chk_zero(input int id);
        cmp("rst_locked", id, {15'd0, a1.locked}, 16'd0);
        cmp("rst_err_pulse", id, {15'd0, a1.err_pulse}, 16'd0);
        cmp("rst_lost_pulse", id, {15'd0, a1.lost_pulse}, 16'd0);
        cmp("rst_err_count", id, a1.err_count, 16'd0);
    endtask

    // Asynchronous reset in the middle of the low phase, checked before any edge.
    task automatic async_reset(input int id);
        #2 RST = 1'b1;
        #1 chk_zero(id);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        RST = 1'b1;
        a1.in_valid = 1'b0; a1.in_data = 16'd0; a1.clr_count = 1'b0;
        a2.in_valid = 1'b0; a2.in_data = 16'd0; a2.clr_count = 1'b0;

        seq[0] = 16'h0000;
        for (int i = 1; i < 32; i++) seq[i] = gen_f(seq[i-1]);
        h[0] = 16'h1234;
        for (int i = 1; i < 8; i++) h[i] = gen_f(h[i-1]);

        repeat (2) @(negedge CLK);
        chk_zero(100);
        cmp("rst_u2_locked", 100, {15'd0, a2.locked}, 16'd0);
        cmp("rst_u2_err_count", 100, {12'd0, a2.err_count}, 16'd0);
        RST = 1'b0;

        // Known stream values from the generator definition.
        cmp("seq1", 101, seq[1], 16'h0021);
        cmp("seq4", 101, seq[4], 16'h01E8);

        //           v  data                 clr lk ep lp cnt
        tbl[0]  = mk(1, seq[0],              0,  0, 0, 0, 16'd0);
        tbl[1]  = mk(1, seq[1],              0,  0, 0, 0, 16'd0);
        tbl[2]  = mk(1, seq[2],              0,  0, 0, 0, 16'd0);
        tbl[3]  = mk(1, seq[3],              0,  0, 0, 0, 16'd0);
        tbl[4]  = mk(1, seq[4],              0,  1, 0, 0, 16'd0);
        tbl[5]  = mk(1, 16'h01E9,            0,  1, 1, 0, 16'd1);
        tbl[6]  = mk(1, seq[6],              0,  1, 0, 0, 16'd1);
        tbl[7]  = mk(1, seq[7],              0,  1, 0, 0, 16'd1);
        tbl[8]  = mk(0, 16'hFFFF,            0,  1, 0, 0, 16'd1);
        tbl[9]  = mk(1, seq[8],              0,  1, 0, 0, 16'd1);
        tbl[10] = mk(1, seq[9] ^ 16'h8000,   0,  1, 1, 0, 16'd2);
        tbl[11] = mk(1, seq[10] ^ 16'h0001,  0,  1, 1, 0, 16'd3);
        tbl[12] = mk(1, seq[11] ^ 16'h0001,  0,  0, 1, 1, 16'd4);
        tbl[13] = mk(0, 16'h0000,            0,  0, 0, 0, 16'd4);
        tbl[14] = mk(1, seq[0],              0,  0, 0, 0, 16'd4);
        tbl[15] = mk(1, seq[1],              0,  0, 0, 0, 16'd4);
        tbl[16] = mk(1, h[0],                0,  0, 0, 0, 16'd4);
        tbl[17] = mk(1, h[1],                0,  0, 0, 0, 16'd4);
        tbl[18] = mk(1, h[2],                0,  0, 0, 0, 16'd4);
        tbl[19] = mk(1, h[3],                0,  0, 0, 0, 16'd4);
        tbl[20] = mk(1, h[4],                0,  1, 0, 0, 16'd4);
        tbl[21] = mk(0, 16'h0000,            1,  1, 0, 0, 16'd0);
        tbl[22] = mk(1, h[5],                0,  1, 0, 0, 16'd0);

        for (int i = 0; i < 23; i++)
            step(1, tbl[i].v, tbl[i].d, tbl[i].clr, tbl[i].lk, tbl[i].ep,
                 tbl[i].lp, tbl[i].cnt, i);

        // Mid-LOCKED reset while a pulse and a nonzero count are showing.
        step(1, 1, h[6] ^ 16'h0100, 0, 1, 1, 0, 16'd1, 200);
        async_reset(201);

        // Lock point with 1..3 idle cycles between words.
        for (int k = 0; k < 5; k++) begin
            step(1, 1, seq[k], 0, (k == 4), 0, 0, 16'd0, 300 + k * 10);
            for (int g = 0; g < 1 + (k % 3); g++)
                step(1, 0, 16'hA5A5, 0, (k == 4), 0, 0, 16'd0, 301 + k * 10 + g);
        end

        // Mid-ACQUIRE reset (three matches in), then reseed from HUNT.
        async_reset(400);
        for (int k = 0; k < 4; k++) step(1, 1, seq[k], 0, 0, 0, 0, 16'd0, 410 + k);
        async_reset(420);
        for (int k = 4; k < 9; k++) step(1, 1, seq[k], 0, (k == 8), 0, 0, 16'd0, 430 + k);

        // Saturation on the 4-bit counter (LOSS_CNT 15 keeps lock).
        for (int k = 0; k < 5; k++) step(2, 1, seq[k], 0, (k == 4), 0, 0, 16'd0, 500 + k);
        for (int k = 5; k < 19; k++)
            step(2, 1, seq[k] ^ 16'h0001, 0, 1, 1, 0, 16'(k - 4), 500 + k);
        step(2, 1, seq[19], 0, 1, 0, 0, 16'd14, 519);
        step(2, 1, seq[20] ^ 16'h0001, 0, 1, 1, 0, 16'd15, 520);
        step(2, 1, seq[21] ^ 16'h0001, 0, 1, 1, 0, 16'd15, 521);
        step(2, 1, seq[22] ^ 16'h0001, 0, 1, 1, 0, 16'd15, 522);
        step(2, 1, seq[23] ^ 16'h0001, 1, 1, 1, 0, 16'd0, 523);
        step(2, 0, 16'h0000, 0, 1, 0, 0, 16'd0, 524);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
